// File: rtl/scrub_monitor_mc_if.sv
// rtl/scrub_monitor_mc_if.sv - REG_BUS register access interface
interface REG_BUS #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    error;

  modport in  (input addr, write, wdata, wstrb, valid, output rdata, ready, error);
  modport out (output addr, write, wdata, wstrb, valid, input rdata, ready, error);
endinterface

// File: rtl/scrub_monitor_mc.sv
// rtl/scrub_monitor_mc.sv - scrub error interval/density monitor with register bus
module scrub_monitor_mc #(
  parameter int unsigned IN_DATA_WIDTH = 100,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned THR_RESET     = 100,
  parameter int unsigned WINDOW_LEN    = 1024
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [IN_DATA_WIDTH-1:0] scrub_i,
  REG_BUS.in                       bus_if,
  output logic                     interr_o
);

  localparam int unsigned POP_W = $clog2(IN_DATA_WIDTH + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW_LEN);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = '1;
  localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(WINDOW_LEN - 1);

  logic [CNT_WIDTH-1:0]  since_q, since_d;
  logic                  have_prev_q, have_prev_d;
  logic [CNT_WIDTH-1:0]  last_q, last_d;
  logic [CNT_WIDTH-1:0]  min_q, min_d;
  logic [CNT_WIDTH-1:0]  thr_q, thr_d;
  logic [DATA_WIDTH-1:0] evcnt_q, evcnt_d;
  logic [DATA_WIDTH-1:0] density_q, density_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic                  irq_q, irq_d;
  logic                  win_done_q, win_done_d;
  logic                  en_q, en_d;
  logic                  irq_en_q, irq_en_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic [POP_W-1:0]      pop;
  logic                  ev;
  logic [CNT_WIDTH-1:0]  ival;
  logic [DATA_WIDTH:0]   acc_sum;
  logic [DATA_WIDTH-1:0] acc_sat;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  acc_go;
  logic                  is_wr;
  logic                  irq_set, irq_clr, win_set, win_clr;

  assign addr   = bus_if.addr;
  assign acc_go = bus_if.valid & ~ready_q;
  assign is_wr  = acc_go & bus_if.write;

  // Number of flagged bits this cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < IN_DATA_WIDTH; i++) begin
      pop = pop + POP_W'(scrub_i[i]);
    end
  end

  assign ev      = en_q & (|scrub_i);
  assign ival    = (since_q == CNT_MAX) ? CNT_MAX : since_q + 1'b1;
  assign acc_sum = {1'b0, acc_q} + (DATA_WIDTH + 1)'(pop);
  assign acc_sat = acc_sum[DATA_WIDTH] ? DATA_MAX : acc_sum[DATA_WIDTH-1:0];

  // Next state of monitor counters, window accumulator and register file.
  always_comb begin
    since_d     = since_q;
    have_prev_d = have_prev_q;
    last_d      = last_q;
    min_d       = min_q;
    thr_d       = thr_q;
    evcnt_d     = evcnt_q;
    density_d   = density_q;
    acc_d       = acc_q;
    win_cnt_d   = win_cnt_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    irq_set     = 1'b0;
    irq_clr     = 1'b0;
    win_set     = 1'b0;
    win_clr     = 1'b0;

    if (en_q) begin
      if (ev) begin
        since_d     = '0;
        have_prev_d = 1'b1;
        if (evcnt_q != DATA_MAX) evcnt_d = evcnt_q + 1'b1;
        if (have_prev_q) begin
          last_d = ival;
          if (ival < min_q) min_d = ival;
          if ((thr_q != '0) && (ival < thr_q)) irq_set = 1'b1;
        end
      end else if (since_q != CNT_MAX) begin
        since_d = since_q + 1'b1;
      end

      if (win_cnt_q == WIN_LAST) begin
        density_d = acc_sat;
        acc_d     = '0;
        win_cnt_d = '0;
        win_set   = 1'b1;
      end else begin
        acc_d     = acc_sat;
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end

    // Bus writes take priority over the counters, except where an event
    // landing in the same cycle must still be reflected.
    if (is_wr) begin
      case (addr)
        ADDR_WIDTH'(0): begin
          irq_clr = bus_if.wstrb[0] & bus_if.wdata[0];
          win_clr = bus_if.wstrb[0] & bus_if.wdata[1];
        end
        ADDR_WIDTH'(3): begin
          for (int i = 0; i < CNT_WIDTH; i++) begin
            thr_d[i] = bus_if.wstrb[i/8] ? bus_if.wdata[i] : thr_q[i];
          end
        end
        ADDR_WIDTH'(4): begin
          if (bus_if.wstrb[0]) begin
            en_d     = bus_if.wdata[0];
            irq_en_d = bus_if.wdata[1];
          end
        end
        ADDR_WIDTH'(5): evcnt_d = ev ? DATA_WIDTH'(1) : '0;
        ADDR_WIDTH'(6): min_d   = (ev && have_prev_q) ? ival : CNT_MAX;
        default: ;
      endcase
    end

    // Leaving the enabled state forgets the previous event.
    if (en_q && !en_d) have_prev_d = 1'b0;
  end

  assign irq_d      = irq_set | (irq_q & ~irq_clr);
  assign win_done_d = win_set | (win_done_q & ~win_clr);

  // Read data, error and one-cycle ready for the access sampled this edge.
  always_comb begin
    rdata_d = '0;
    error_d = 1'b0;
    ready_d = acc_go;
    if (acc_go) begin
      case (addr)
        ADDR_WIDTH'(0): rdata_d = DATA_WIDTH'({win_done_q, irq_q});
        ADDR_WIDTH'(1): begin
          rdata_d = DATA_WIDTH'(last_q);
          error_d = bus_if.write;
        end
        ADDR_WIDTH'(2): begin
          rdata_d = density_q;
          error_d = bus_if.write;
        end
        ADDR_WIDTH'(3): rdata_d = DATA_WIDTH'(thr_q);
        ADDR_WIDTH'(4): rdata_d = DATA_WIDTH'({irq_en_q, en_q});
        ADDR_WIDTH'(5): rdata_d = evcnt_q;
        ADDR_WIDTH'(6): rdata_d = DATA_WIDTH'(min_q);
        default:        error_d = 1'b1;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      since_q     <= '0;
      have_prev_q <= 1'b0;
      last_q      <= '0;
      min_q       <= CNT_MAX;
      thr_q       <= CNT_WIDTH'(THR_RESET);
      evcnt_q     <= '0;
      density_q   <= '0;
      acc_q       <= '0;
      win_cnt_q   <= '0;
      irq_q       <= 1'b0;
      win_done_q  <= 1'b0;
      en_q        <= 1'b1;
      irq_en_q    <= 1'b1;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      since_q     <= since_d;
      have_prev_q <= have_prev_d;
      last_q      <= last_d;
      min_q       <= min_d;
      thr_q       <= thr_d;
      evcnt_q     <= evcnt_d;
      density_q   <= density_d;
      acc_q       <= acc_d;
      win_cnt_q   <= win_cnt_d;
      irq_q       <= irq_d;
      win_done_q  <= win_done_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  assign bus_if.ready = ready_q;
  assign bus_if.rdata = rdata_q;
  assign bus_if.error = error_q;
  assign interr_o     = irq_q & irq_en_q;

endmodule

// File: doc/scrub_monitor_mc.md
Name: scrub_monitor_mc

Overview:
Parametrised successor of the single-threshold scrub error monitor. Watches a vector of scrub error flags, measures the cycle interval between error events, tracks minimum interval, event count and windowed bit-flip density, and raises a maskable sticky interrupt when two events arrive closer than a software-programmable threshold. All state is exposed on the REG_BUS register interface; threshold, enable and interrupt clear are writable.

Parameters:
IN_DATA_WIDTH, 100, number of scrub error input bits
ADDR_WIDTH, 3, REG_BUS address width (8 word registers)
DATA_WIDTH, 32, REG_BUS data width
CNT_WIDTH, 16, width of interval/threshold counters (≤ DATA_WIDTH)
THR_RESET, 100, reset value of THRESHOLD register
WINDOW_LEN, 1024, density accumulation window in cycles (≥ 2)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
scrub_i  in  IN_DATA_WIDTH  per-bit scrub error flags, sampled each rising edge
bus_if  REG_BUS.in modport  ADDR_WIDTH/DATA_WIDTH  register slave (addr, write, wdata, wstrb, valid, rdata, ready, error)
interr_o  out  1  interrupt = STATUS.irq & CTRL.irq_en

Behaviour:
- Event: cycle with CTRL.en=1 and |scrub_i. pop = popcount(scrub_i).
- since_q: +1 per enabled non-event cycle, saturating at 2^CNT_WIDTH-1; on event, interval = sat(since_q+1), since_q←0, have_prev←1.
- On event with have_prev=1: LAST_INTERVAL←interval; MIN_INTERVAL←min(MIN_INTERVAL, interval); if THRESHOLD≠0 and interval<THRESHOLD set STATUS.irq. First event after reset/enable only arms have_prev.
- Example: event, 98 quiet cycles, event → interval 99 → irq at THRESHOLD=100; 99 quiet cycles → interval 100 → no irq.
- EVENT_COUNT: +1 per event, saturates at all-ones.
- Density: win_cnt 0..WINDOW_LEN-1 while enabled; acc += pop (saturating DATA_WIDTH). At win_cnt=WINDOW_LEN-1: DENSITY←sat(acc+pop), acc←0, win_cnt←0, STATUS.win_done←1.
- CTRL.en 1→0: counters/window freeze, have_prev←0, events ignored; registers retain values.
- Register map (word index): 0 STATUS RO/W1C (bit0 irq, bit1 win_done; others 0); 1 LAST_INTERVAL RO; 2 DENSITY RO; 3 THRESHOLD RW [CNT_WIDTH-1:0]; 4 CTRL RW (bit0 en, bit1 irq_en); 5 EVENT_COUNT RO, any write clears to 0; 6 MIN_INTERVAL RO, any write resets to all-ones; 7 reserved reads 0, error=1.
- Writes to RO regs 1, 2: ignored, error=1. wstrb byte-enables honoured on THRESHOLD/CTRL/STATUS.
- Handshake: valid sampled on rising edge; ready=1 for exactly one cycle the following cycle with rdata/error valid; access commits on that cycle. Master holds addr/write/wdata until ready. ready never high without preceding valid; back-to-back access needs valid re-sampled after ready cycle.
- Simultaneous: hardware set beats W1C clear of same bit; event and EVENT_COUNT clear same cycle → result 1; MIN_INTERVAL reset and event same cycle → interval.
- Reset values: interr_o=0, ready=0, rdata=0, error=0, STATUS=0, LAST_INTERVAL=0, DENSITY=0, THRESHOLD=THR_RESET, CTRL=2'b11, EVENT_COUNT=0, MIN_INTERVAL=all-ones, since_q=0, have_prev=0, win_cnt=0, acc=0.
- Reset asserted mid-transaction: ready drops immediately, transaction lost; all state to reset values.

Test Plan:
- Reset, single bit event, 98 quiet cycles, event; read addr0 → 0x1, interr_o=1, addr1 → 99.
- W1C 0x1 to addr0; event, 99 quiet, event → addr0=0x0, interr_o=0, addr1=100, addr6=99.
- Event, 96 quiet, event → addr1=97, addr5 counts all events so far; write addr5 → reads 0.
- Write THRESHOLD=0, events 1 cycle apart → no irq; write CTRL=0x1 with irq pending → interr_o=0, addr0 bit0=1.
- scrub_i=all ones (100 bits) for WINDOW_LEN=16 cycles → addr2=1600, STATUS.win_done=1; 3 bits/cycle → 48.
- Read addr7 → error=1, rdata=0; write addr1 → error=1, value unchanged; assert rstn_i low during ready cycle → ready=0 immediately, regs reset.
